// File: rtl/intr_service_agent.sv
// intr_service_agent: APB initiator that programs and verifies the interrupt
// controller's priority table, then services interrupts and logs their IDs.
module intr_service_agent #(
  parameter int unsigned NUM_INTR       = 16,
  parameter int unsigned SERVICE_CYCLES = 2,
  parameter int unsigned LOG_DEPTH      = 8
) (
  input  logic                               pclk_i,
  input  logic                               prst_i,
  input  logic                               cfg_start_i,
  input  logic [4*NUM_INTR-1:0]              cfg_prio_i,
  output logic                               cfg_busy_o,
  output logic                               cfg_done_o,
  output logic                               cfg_err_o,
  output logic [7:0]                         paddr_o,
  output logic [7:0]                         pwdata_o,
  output logic                               pwrite_o,
  output logic                               penable_o,
  input  logic [7:0]                         prdata_i,
  input  logic                               pready_i,
  input  logic                               pslverr_i,
  input  logic [3:0]                         intr_to_service_i,
  input  logic                               intr_valid_i,
  output logic                               intr_serviced_o,
  output logic [3:0]                         log_id_o,
  output logic                               log_valid_o,
  input  logic                               log_rd_i,
  output logic [$clog2(LOG_DEPTH+1)-1:0]     log_count_o,
  output logic                               log_ovf_o
);

  localparam int unsigned IDX_W = (NUM_INTR > 1) ? $clog2(NUM_INTR) : 1;
  localparam int unsigned CNT_W = (SERVICE_CYCLES > 0) ? $clog2(SERVICE_CYCLES + 1) : 1;
  localparam int unsigned PTR_W = $clog2(LOG_DEPTH);
  localparam int unsigned OCC_W = $clog2(LOG_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INTR - 1);

  typedef enum logic [2:0] {
    C_IDLE, C_WR_ACC, C_WR_GAP, C_RD_ACC, C_RD_GAP, C_DONE
  } cfg_state_e;

  typedef enum logic [1:0] {
    S_WAIT, S_SERVICE, S_ACK, S_GUARD
  } svc_state_e;

  cfg_state_e        cfg_state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              busy_q, done_q, err_q;
  logic [7:0]        paddr_q, pwdata_q;
  logic              pwrite_q, penable_q;

  svc_state_e        svc_state_q;
  logic [CNT_W-1:0]  svc_cnt_q;
  logic [3:0]        svc_id_q;
  logic              serviced_q;

  logic [3:0]        log_mem_q [LOG_DEPTH];
  logic [PTR_W-1:0]  log_wr_ptr_q, log_rd_ptr_q;
  logic [OCC_W-1:0]  log_count_q;
  logic              log_ovf_q;

  logic [IDX_W-1:0]  idx_nxt_c;
  logic [3:0]        prio_cur_c, prio_nxt_c;
  logic              cfg_clr_c;
  logic              log_full_c, push_req_c, pop_c, push_c, drop_c;

  // Table entry lookup for the current and the following address
  always_comb begin
    idx_nxt_c  = idx_q + IDX_W'(1);
    prio_cur_c = cfg_prio_i[{idx_q, 2'b00} +: 4];
    prio_nxt_c = cfg_prio_i[{idx_nxt_c, 2'b00} +: 4];
    cfg_clr_c  = cfg_start_i && ((cfg_state_q == C_IDLE) || (cfg_state_q == C_DONE));
  end

  // Programming sequencer: write every entry, then read each back and compare
  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      cfg_state_q <= C_IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      penable_q   <= 1'b0;
    end else begin
      case (cfg_state_q)
        C_IDLE, C_DONE: begin
          if (cfg_start_i) begin
            cfg_state_q <= C_WR_ACC;
            idx_q       <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= {4'b0000, cfg_prio_i[3:0]};
            pwrite_q    <= 1'b1;
            penable_q   <= 1'b1;
          end
        end
        C_WR_ACC: begin
          if (pready_i) begin
            if (pslverr_i) err_q <= 1'b1;
            cfg_state_q <= C_WR_GAP;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            penable_q   <= 1'b0;
          end
        end
        C_WR_GAP: begin
          penable_q <= 1'b1;
          if (idx_q == LAST_IDX) begin
            cfg_state_q <= C_RD_ACC;
            idx_q       <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
          end else begin
            cfg_state_q <= C_WR_ACC;
            idx_q       <= idx_nxt_c;
            paddr_q     <= 8'(idx_nxt_c);
            pwdata_q    <= {4'b0000, prio_nxt_c};
            pwrite_q    <= 1'b1;
          end
        end
        C_RD_ACC: begin
          if (pready_i) begin
            if (pslverr_i || (prdata_i != {4'b0000, prio_cur_c})) err_q <= 1'b1;
            cfg_state_q <= C_RD_GAP;
            paddr_q     <= '0;
            penable_q   <= 1'b0;
          end
        end
        C_RD_GAP: begin
          if (idx_q == LAST_IDX) begin
            cfg_state_q <= C_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            cfg_state_q <= C_RD_ACC;
            idx_q       <= idx_nxt_c;
            paddr_q     <= 8'(idx_nxt_c);
            penable_q   <= 1'b1;
          end
        end
        default: cfg_state_q <= C_IDLE;
      endcase
    end
  end

  // Service sequencer: capture ID, wait the service time, acknowledge, guard
  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      svc_state_q <= S_WAIT;
      svc_cnt_q   <= '0;
      svc_id_q    <= '0;
      serviced_q  <= 1'b0;
    end else begin
      case (svc_state_q)
        S_WAIT: begin
          if (done_q && intr_valid_i) begin
            svc_state_q <= S_SERVICE;
            svc_id_q    <= intr_to_service_i;
            svc_cnt_q   <= CNT_W'(SERVICE_CYCLES);
          end
        end
        S_SERVICE: begin
          if (svc_cnt_q == '0) begin
            svc_state_q <= S_ACK;
            serviced_q  <= 1'b1;
          end else begin
            svc_cnt_q <= svc_cnt_q - CNT_W'(1);
          end
        end
        S_ACK: begin
          svc_state_q <= S_GUARD;
          serviced_q  <= 1'b0;
        end
        S_GUARD:  svc_state_q <= S_WAIT;
        default:  svc_state_q <= S_WAIT;
      endcase
    end
  end

  // Log push/pop qualification; a full log still accepts a push when popped
  always_comb begin
    log_full_c = (log_count_q == OCC_W'(LOG_DEPTH));
    push_req_c = (svc_state_q == S_ACK);
    pop_c      = log_rd_i && (log_count_q != '0);
    push_c     = push_req_c && (!log_full_c || pop_c);
    drop_c     = push_req_c && log_full_c && !pop_c;
  end

  // Serviced-ID log storage, pointers, occupancy and overflow flag
  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      for (int i = 0; i < int'(LOG_DEPTH); i++) log_mem_q[i] <= '0;
      log_wr_ptr_q <= '0;
      log_rd_ptr_q <= '0;
      log_count_q  <= '0;
      log_ovf_q    <= 1'b0;
    end else begin
      if (push_c) begin
        log_mem_q[log_wr_ptr_q] <= svc_id_q;
        log_wr_ptr_q            <= log_wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) log_rd_ptr_q <= log_rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   log_count_q <= log_count_q + OCC_W'(1);
        2'b01:   log_count_q <= log_count_q - OCC_W'(1);
        default: log_count_q <= log_count_q;
      endcase
      if (drop_c)         log_ovf_q <= 1'b1;
      else if (cfg_clr_c) log_ovf_q <= 1'b0;
    end
  end

  assign cfg_busy_o      = busy_q;
  assign cfg_done_o      = done_q;
  assign cfg_err_o       = err_q;
  assign paddr_o         = paddr_q;
  assign pwdata_o        = pwdata_q;
  assign pwrite_o        = pwrite_q;
  assign penable_o       = penable_q;
  assign intr_serviced_o = serviced_q;
  assign log_id_o        = log_mem_q[log_rd_ptr_q];
  assign log_valid_o     = (log_count_q != '0);
  assign log_count_o     = log_count_q;
  assign log_ovf_o       = log_ovf_q;

endmodule

// File: tb/tb_intr_service_agent.sv
// Bench for intr_service_agent: APB responder, table-driven service vectors,
// hand sequences for reset and programming, randomized servicing vs a model.
module tb_intr_service_agent;
  localparam int unsigned NI = 16;
  localparam int unsigned SC = 2;
  localparam int unsigned LD = 8;

  logic        clk = 1'b0;
  logic        prst_i = 1'b1;
  logic        cfg_start_i = 1'b0;
  logic [4*NI-1:0] cfg_prio_i = '0;
  logic        cfg_busy_o, cfg_done_o, cfg_err_o;
  logic [7:0]  paddr_o, pwdata_o;
  logic        pwrite_o, penable_o;
  logic [7:0]  prdata_i = '0;
  logic        pready_i = 1'b0;
  logic        pslverr_i = 1'b0;
  logic [3:0]  intr_to_service_i = '0;
  logic        intr_valid_i = 1'b0;
  logic        intr_serviced_o;
  logic [3:0]  log_id_o;
  logic        log_valid_o;
  logic        log_rd_i = 1'b0;
  logic [3:0]  log_count_o;
  logic        log_ovf_o;

  int n_chk = 0;
  int n_pass = 0;

  intr_service_agent #(.NUM_INTR(NI), .SERVICE_CYCLES(SC), .LOG_DEPTH(LD)) dut (
    .pclk_i(clk), .prst_i(prst_i), .cfg_start_i(cfg_start_i), .cfg_prio_i(cfg_prio_i),
    .cfg_busy_o(cfg_busy_o), .cfg_done_o(cfg_done_o), .cfg_err_o(cfg_err_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o), .penable_o(penable_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .intr_to_service_i(intr_to_service_i), .intr_valid_i(intr_valid_i),
    .intr_serviced_o(intr_serviced_o), .log_id_o(log_id_o), .log_valid_o(log_valid_o),
    .log_rd_i(log_rd_i), .log_count_o(log_count_o), .log_ovf_o(log_ovf_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] all_outs();
    return {cfg_busy_o, cfg_done_o, cfg_err_o, paddr_o, pwdata_o, pwrite_o, penable_o,
            intr_serviced_o, log_id_o, log_valid_o, log_count_o, log_ovf_o};
  endfunction

  // APB responder with configurable wait states and fault injection
  typedef struct packed { logic wr; logic [7:0] addr; logic [7:0] data; } tx_t;
  tx_t        tx_q[$];
  int         n_wait = 0;
  int         bad_rd = -1;
  int         err_wr = -1;
  int         acc_cyc = 0;
  logic [7:0] rmem [16];

  always @(negedge clk) begin
    if (penable_o) begin
      pready_i = (acc_cyc >= n_wait);
      acc_cyc++;
      if (pwrite_o) begin
        pslverr_i = pready_i && (int'(paddr_o) == err_wr);
        prdata_i  = 8'h00;
        if (pready_i) begin
          rmem[paddr_o[3:0]] = pwdata_o;
          tx_q.push_back('{1'b1, paddr_o, pwdata_o});
        end
      end else begin
        pslverr_i = 1'b0;
        prdata_i  = (int'(paddr_o) == bad_rd) ? 8'h00 : rmem[paddr_o[3:0]];
        if (pready_i) tx_q.push_back('{1'b0, paddr_o, 8'h00});
      end
    end else begin
      acc_cyc   = 0;
      pready_i  = 1'b0;
      pslverr_i = 1'b0;
      prdata_i  = 8'h00;
    end
  end

  logic [3:0] tab [16] = '{4'd10, 4'd7, 4'd5, 4'd15, 4'd6, 4'd3, 4'd8, 4'd4,
                           4'd0, 4'd1, 4'd11, 4'd2, 4'd13, 4'd9, 4'd14, 4'd12};

  // One full programming run; checks timing, transfer list and error flag
  task automatic program_run(input int nw, input int badrd, input int errwr,
                             input bit mid_start, input bit vld_busy,
                             input int exp_cyc, input logic exp_err, input string tag);
    int k;
    int serv_cnt;
    int bad_tx;
    bit seen;
    tx_q.delete();
    n_wait = nw; bad_rd = badrd; err_wr = errwr;
    k = 0; serv_cnt = 0; bad_tx = 0; seen = 1'b0;
    @(negedge clk);
    cfg_start_i = 1'b1;
    @(posedge clk);
    #1 cfg_start_i = 1'b0;
    while (!seen && k < 400) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check({tag, "_first_acc"}, {28'd0, cfg_busy_o, penable_o, pwrite_o, cfg_done_o}, 32'hE);
        check({tag, "_first_addr"}, {24'd0, paddr_o}, 32'h0);
        if (vld_busy) begin intr_valid_i = 1'b1; intr_to_service_i = 4'd5; end
      end
      cfg_start_i = mid_start && (k == 10);
      if (intr_serviced_o) serv_cnt++;
      if (cfg_done_o) seen = 1'b1;
    end
    intr_valid_i = 1'b0;
    cfg_start_i  = 1'b0;
    check({tag, "_done_cycle"}, k, exp_cyc);
    check({tag, "_err"}, {31'd0, cfg_err_o}, {31'd0, exp_err});
    check({tag, "_busy_low"}, {31'd0, cfg_busy_o}, 32'd0);
    check({tag, "_tx_count"}, tx_q.size(), 2 * NI);
    for (int i = 0; i < tx_q.size() && i < 2 * int'(NI); i++) begin
      if (i < int'(NI)) begin
        if (tx_q[i] !== '{1'b1, 8'(i), {4'b0, tab[i]}}) bad_tx++;
      end else begin
        if (tx_q[i] !== '{1'b0, 8'(i - int'(NI)), 8'h00}) bad_tx++;
      end
    end
    check({tag, "_tx_content_errs"}, bad_tx, 0);
    if (vld_busy) check({tag, "_no_ack_before_done"}, serv_cnt, 0);
  endtask

  // Present one ID and check the acknowledge lands SC+1 edges after sampling
  task automatic do_service(input logic [3:0] id, input string tag);
    logic [31:0] pat;
    pat = '0;
    @(negedge clk);
    intr_valid_i = 1'b1;
    intr_to_service_i = id;
    @(posedge clk);
    #1 intr_valid_i = 1'b0;
    for (int k = 0; k < int'(SC) + 3; k++) begin
      @(negedge clk);
      if (intr_serviced_o) pat[k] = 1'b1;
    end
    check({tag, "_ack_pulse"}, pat, 32'(1) << (SC + 1));
  endtask

  task automatic pop_once();
    @(negedge clk);
    log_rd_i = 1'b1;
    @(posedge clk);
    #1 log_rd_i = 1'b0;
  endtask

  typedef struct { logic [3:0] id; logic [3:0] cnt; logic [3:0] head; logic ovf; } svc_vec_t;
  svc_vec_t svt [10];

  // Randomized servicing reference model (event times in edge numbers)
  logic [3:0] mq[$];
  int  m_edge, m_next_free, m_ack_edge;
  logic [3:0] m_ack_id;
  logic m_ovf, m_serv;

  task automatic model_step(input logic vld, input logic [3:0] id, input logic rd);
    bit push, pop, full;
    m_edge++;
    push = (m_ack_edge >= 0) && (m_edge == m_ack_edge + 1);
    full = (mq.size() == int'(LD));
    pop  = rd && (mq.size() > 0);
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (full && !pop) m_ovf = 1'b1;
      else mq.push_back(m_ack_id);
    end
    if (vld && m_edge >= m_next_free) begin
      m_ack_edge  = m_edge + int'(SC) + 1;
      m_next_free = m_edge + int'(SC) + 4;
      m_ack_id    = id;
    end
    m_serv = (m_edge == m_ack_edge);
  endtask

  initial begin
    logic [31:0] exp_v, act_v;
    logic vld, rd;
    logic [3:0] rid;
    bit seen;

    for (int i = 0; i < int'(NI); i++) cfg_prio_i[4*i +: 4] = tab[i];
    svt[0] = '{4'd3, 4'd1, 4'd3, 1'b0};
    for (int i = 0; i < 9; i++)
      svt[i+1] = '{4'(i), 4'((i < 8) ? i + 1 : 8), 4'd0, (i == 8)};

    // Reset state
    #1 prst_i = 1'b0;
    #1 check("reset_outputs", all_outs(), 32'd0);
    @(negedge clk);
    prst_i = 1'b1;

    // Asynchronous reset mid-sequence
    @(negedge clk);
    cfg_start_i = 1'b1;
    @(posedge clk);
    #1 cfg_start_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (k > 5 && penable_o) seen = 1'b1;
    end
    check("rst_penable_was_high", {31'd0, penable_o}, 32'd1);
    #2 prst_i = 1'b0;
    #1 check("rst_async_outputs", all_outs(), 32'd0);
    @(negedge clk);
    check("rst_held_outputs", all_outs(), 32'd0);
    prst_i = 1'b1;

    // Zero-wait programming, then wait states with injected faults
    program_run(0, -1, -1, 1'b0, 1'b0, 65, 1'b0, "prog0");
    program_run(2, 5, 3, 1'b0, 1'b0, 129, 1'b1, "prog_ws");
    // Start pulse while busy and interrupts presented before done
    program_run(0, -1, -1, 1'b1, 1'b1, 65, 1'b0, "prog_busy");

    // Service vectors: single ID, then fill past capacity
    for (int i = 0; i < 10; i++) begin
      do_service(svt[i].id, $sformatf("svc%0d", i));
      check($sformatf("svc%0d_log", i), {22'd0, log_valid_o, log_count_o, log_id_o, log_ovf_o},
            {22'd0, 1'b1, svt[i].cnt, svt[i].head, svt[i].ovf});
      if (i == 0) begin
        pop_once();
        @(negedge clk);
        check("svc0_popped", {27'd0, log_valid_o, log_count_o}, 32'd0);
      end
    end

    // Drain: oldest eight IDs in order, then empty
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("pop%0d_head", i), {27'd0, log_valid_o, log_id_o}, {27'd0, 1'b1, 4'(i)});
      pop_once();
    end
    @(negedge clk);
    check("drained", {27'd0, log_valid_o, log_count_o}, 32'd0);

    // Reprogram clears the overflow flag
    program_run(0, -1, -1, 1'b0, 1'b0, 65, 1'b0, "prog_clr");
    check("ovf_cleared", {31'd0, log_ovf_o}, 32'd0);

    // Randomized servicing against the model
    m_edge = 0; m_next_free = 1; m_ack_edge = -10; m_ack_id = '0;
    m_ovf = 1'b0; m_serv = 1'b0;
    mq.delete();
    for (int it = 0; it < 600; it++) begin
      @(negedge clk);
      exp_v = {20'd0, m_serv, (mq.size() > 0), 4'(mq.size()),
               (mq.size() > 0) ? mq[0] : 4'd0, m_ovf};
      act_v = {20'd0, intr_serviced_o, log_valid_o, log_count_o,
               (mq.size() > 0) ? log_id_o : 4'd0, log_ovf_o};
      check($sformatf("rand%0d", it), act_v, exp_v);
      vld = ($urandom_range(0, 2) == 0);
      rid = 4'($urandom_range(0, 15));
      rd  = (it < 300) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 0);
      intr_valid_i = vld;
      intr_to_service_i = rid;
      log_rd_i = rd;
      model_step(vld, rid, rd);
    end
    @(negedge clk);
    intr_valid_i = 1'b0;
    log_rd_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
